// File: rtl/plc_counter.sv
// PLC counter element (CTU/CTD/CTUD): counts rising edges of cu/cd and drives DN/OV/UN.
// ACC and flags update on the same posedge that samples the edge. No backpressure.
module plc_counter #(
  parameter int ACC_LEN    = 8,
  parameter int PRESET_LEN = 8,
  parameter int TYPE_LEN   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic                  i_cu,
  input  logic                  i_cd,
  input  logic                  i_clr,
  input  logic [TYPE_LEN-1:0]   i_type,
  input  logic [PRESET_LEN-1:0] i_preset,
  output logic [ACC_LEN-1:0]    o_acc,
  output logic                  o_dn,
  output logic                  o_ov,
  output logic                  o_un
);

  localparam logic [TYPE_LEN-1:0] CTU  = TYPE_LEN'(0);
  localparam logic [TYPE_LEN-1:0] CTD  = TYPE_LEN'(1);
  localparam logic [TYPE_LEN-1:0] CTUD = TYPE_LEN'(2);

  logic [ACC_LEN-1:0]  r_acc;
  logic                r_dn;
  logic                r_ov;
  logic                r_un;
  logic                r_cu_q;
  logic                r_cd_q;
  logic [TYPE_LEN-1:0] r_type_q;

  logic [ACC_LEN-1:0]  w_acc_nxt;
  logic                w_dn_nxt;
  logic                w_ov_nxt;
  logic                w_un_nxt;
  logic [TYPE_LEN-1:0] w_type_nxt;
  logic [ACC_LEN-1:0]  w_preset_ext;
  logic                w_up_ev;
  logic                w_dn_ev;
  logic                w_inc;
  logic                w_dec;

  // Invalid type codes hold the accumulator instead of reloading it.
  function automatic logic [ACC_LEN-1:0] f_load(input logic [TYPE_LEN-1:0] t,
                                                input logic [ACC_LEN-1:0]  cur,
                                                input logic [ACC_LEN-1:0]  pre);
    case (t)
      CTU, CTUD: f_load = '0;
      CTD:       f_load = pre;
      default:   f_load = cur;
    endcase
  endfunction

  assign w_preset_ext = ACC_LEN'(i_preset);
  assign w_up_ev      = i_en & i_cu & ~r_cu_q;
  assign w_dn_ev      = i_en & i_cd & ~r_cd_q;

  always_comb begin
    w_acc_nxt  = r_acc;
    w_ov_nxt   = r_ov;
    w_un_nxt   = r_un;
    w_type_nxt = r_type_q;
    w_inc      = 1'b0;
    w_dec      = 1'b0;
    w_dn_nxt   = 1'b0;

    if (i_type != r_type_q) begin
      w_type_nxt = i_type;
      w_acc_nxt  = f_load(i_type, r_acc, w_preset_ext);
      w_ov_nxt   = 1'b0;
      w_un_nxt   = 1'b0;
    end else if (i_clr) begin
      w_acc_nxt  = f_load(r_type_q, r_acc, w_preset_ext);
      w_ov_nxt   = 1'b0;
      w_un_nxt   = 1'b0;
    end else begin
      case (r_type_q)
        CTU:  w_inc = w_up_ev;
        CTD:  w_dec = w_dn_ev;
        CTUD: begin
          w_inc = w_up_ev & ~w_dn_ev;
          w_dec = w_dn_ev & ~w_up_ev;
        end
        default: ;
      endcase
      if (w_inc) begin
        w_acc_nxt = r_acc + ACC_LEN'(1);
        if (&r_acc) w_ov_nxt = 1'b1;
      end else if (w_dec) begin
        w_acc_nxt = r_acc - ACC_LEN'(1);
        if (r_acc == '0) w_un_nxt = 1'b1;
      end
    end

    // DN follows the post-update accumulator under the post-update type.
    case (w_type_nxt)
      CTU, CTUD: w_dn_nxt = (w_acc_nxt >= w_preset_ext);
      CTD:       w_dn_nxt = (w_acc_nxt == '0);
      default:   w_dn_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc    <= '0;
      r_dn     <= 1'b0;
      r_ov     <= 1'b0;
      r_un     <= 1'b0;
      r_cu_q   <= 1'b0;
      r_cd_q   <= 1'b0;
      r_type_q <= '1;
    end else begin
      r_acc    <= w_acc_nxt;
      r_dn     <= w_dn_nxt;
      r_ov     <= w_ov_nxt;
      r_un     <= w_un_nxt;
      r_cu_q   <= i_cu;
      r_cd_q   <= i_cd;
      r_type_q <= w_type_nxt;
    end
  end

  assign o_acc = r_acc;
  assign o_dn  = r_dn;
  assign o_ov  = r_ov;
  assign o_un  = r_un;

endmodule
